// File: rtl/mhd_error_accumulator.sv
// Streaming Hamming-distance statistics for the approximate-circuit miter flow.
// Accepts N (exact, approx) pairs, then reports violation count, HD sum/max and first violation index.
module mhd_error_accumulator #(
   parameter int          WIDTH = 9,
   parameter int unsigned MHD   = 1,
   parameter int          CNT_W = 16,
   parameter int          SUM_W = 24,
   localparam int         HW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_exact,
   input  logic [WIDTH-1:0] in_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] hd_sum,
   output logic [HW-1:0]    hd_max,
   output logic             first_viol_valid,
   output logic [CNT_W-1:0] first_viol_idx
);

   // Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
   // in_ready is registered and never depends on in_valid in the same cycle.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] accepted;
   logic             s1_valid;
   logic [HW-1:0]    s1_hd;
   logic [CNT_W-1:0] s1_idx;

   function automatic logic [HW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [HW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + HW'(v[i]);
      end
      return c;
   endfunction

   logic             accept;
   logic [HW-1:0]    in_hd;
   logic             s1_viol;
   logic [SUM_W:0]   sum_ext;

   assign accept  = in_valid && in_ready;
   assign in_hd   = popcount(in_exact ^ in_approx);
   assign s1_viol = 32'(s1_hd) > MHD;
   // One extra bit catches the carry so the sum clamps instead of wrapping.
   assign sum_ext = {1'b0, hd_sum} + (SUM_W + 1)'(s1_hd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         in_ready         <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         n_lat            <= '0;
         accepted         <= '0;
         s1_valid         <= 1'b0;
         s1_hd            <= '0;
         s1_idx           <= '0;
         err_count        <= '0;
         hd_sum           <= '0;
         hd_max           <= '0;
         first_viol_valid <= 1'b0;
         first_viol_idx   <= '0;
      end else begin
         done     <= 1'b0;
         s1_valid <= accept;

         if (accept) begin
            s1_hd  <= in_hd;
            s1_idx <= accepted;
         end

         if (s1_valid) begin
            if (s1_viol) begin
               err_count <= err_count + CNT_W'(1);
               if (!first_viol_valid) begin
                  first_viol_valid <= 1'b1;
                  first_viol_idx   <= s1_idx;
               end
            end
            if (s1_hd > hd_max) begin
               hd_max <= s1_hd;
            end
            hd_sum <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state            <= RUN;
                  busy             <= 1'b1;
                  n_lat            <= num_samples;
                  accepted         <= '0;
                  in_ready         <= (num_samples != '0);
                  err_count        <= '0;
                  hd_sum           <= '0;
                  hd_max           <= '0;
                  first_viol_valid <= 1'b0;
                  first_viol_idx   <= '0;
               end
            end
            RUN: begin
               // in_ready drops right after the N-th transfer, so accepted never exceeds N.
               if (accept) begin
                  accepted <= accepted + CNT_W'(1);
                  if ((accepted + CNT_W'(1)) == n_lat) begin
                     in_ready <= 1'b0;
                  end
               end
               if (accepted == n_lat) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!s1_valid) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mhd_error_accumulator.sv
// Self-checking bench for mhd_error_accumulator: directed and random runs against a list-based model.
// A second instance with a 4-bit sum shares all inputs to exercise saturation.
module tb_mhd_error_accumulator;

   localparam int WIDTH   = 9;
   localparam int MHD     = 1;
   localparam int CNT_W   = 16;
   localparam int SUM_W   = 24;
   localparam int SUM_W_S = 4;
   localparam int HW      = $clog2(WIDTH + 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [CNT_W-1:0]   num_samples;
   logic               in_valid;
   logic [WIDTH-1:0]   in_exact;
   logic [WIDTH-1:0]   in_approx;

   logic               in_ready, busy, done, first_viol_valid;
   logic [CNT_W-1:0]   err_count, first_viol_idx;
   logic [SUM_W-1:0]   hd_sum;
   logic [HW-1:0]      hd_max;

   logic               in_ready_s, busy_s, done_s, first_viol_valid_s;
   logic [CNT_W-1:0]   err_count_s, first_viol_idx_s;
   logic [SUM_W_S-1:0] hd_sum_s;
   logic [HW-1:0]      hd_max_s;

   mhd_error_accumulator #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_exact(in_exact), .in_approx(in_approx),
      .busy(busy), .done(done), .err_count(err_count), .hd_sum(hd_sum), .hd_max(hd_max),
      .first_viol_valid(first_viol_valid), .first_viol_idx(first_viol_idx)
   );

   mhd_error_accumulator #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W), .SUM_W(SUM_W_S)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_exact(in_exact), .in_approx(in_approx),
      .busy(busy_s), .done(done_s), .err_count(err_count_s), .hd_sum(hd_sum_s), .hd_max(hd_max_s),
      .first_viol_valid(first_viol_valid_s), .first_viol_idx(first_viol_idx_s)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] se_q[$];
   logic [WIDTH-1:0] sa_q[$];
   logic [HW-1:0]    exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int s, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (s > lim) ? lim : s;
   endfunction

   // Reference: statistics computed directly from the list of accepted HDs.
   task automatic check_results(input string tag);
      int e, s, m, fv, fi;
      e = 0; s = 0; m = 0; fv = 0; fi = 0;
      foreach (exp_q[i]) begin
         if (int'(exp_q[i]) > MHD) begin
            e++;
            if (fv == 0) begin
               fv = 1;
               fi = i;
            end
         end
         s += int'(exp_q[i]);
         if (int'(exp_q[i]) > m) m = int'(exp_q[i]);
      end
      check({tag, "/err_count"}, 32'(err_count), e);
      check({tag, "/hd_sum"}, 32'(hd_sum), sat(s, SUM_W));
      check({tag, "/hd_max"}, 32'(hd_max), m);
      check({tag, "/fv_valid"}, 32'(first_viol_valid), fv);
      check({tag, "/fv_idx"}, 32'(first_viol_idx), fi);
      check({tag, "/sat_sum"}, 32'(hd_sum_s), sat(s, SUM_W_S));
      check({tag, "/sat_err"}, 32'(err_count_s), e);
      check({tag, "/sat_max"}, 32'(hd_max_s), m);
   endtask

   task automatic push_pair(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] a);
      se_q.push_back(e);
      sa_q.push_back(a);
   endtask

   task automatic push_random(input int count);
      logic [WIDTH-1:0] e, a;
      for (int i = 0; i < count; i++) begin
         e = WIDTH'($urandom);
         case ($urandom_range(0, 2))
            0: a = e;
            1: a = e ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            default: a = WIDTH'($urandom);
         endcase
         push_pair(e, a);
      end
   endtask

   // Driver: mode 0 = back-to-back, 1 = valid toggling, 2 = random valid.
   task automatic run(input string tag, input int n, input int mode, input bit glitch);
      int t, acc, done_at;
      bit v, fin;
      bit exp_rdy;
      exp_q.delete();
      acc = 0;
      fin = 0;
      @(negedge clk);
      check({tag, "/pre_busy"}, 32'(busy), 0);
      check({tag, "/pre_ready"}, 32'(in_ready), 0);
      start = 1'b1;
      num_samples = CNT_W'(n);
      in_valid = 1'b0;
      t = cyc;
      done_at = (n == 0) ? t + 3 : -1;
      for (int k = 0; k < 400 && !fin; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (glitch && cyc == t + 2) begin
            start = 1'b1;
            num_samples = CNT_W'(n + 5);
         end
         if (glitch && cyc == done_at) begin
            start = 1'b1;
            num_samples = CNT_W'(n + 3);
         end
         exp_rdy = (acc < n);
         check({tag, "/in_ready"}, 32'(in_ready), 32'(exp_rdy));
         check({tag, "/busy"}, 32'(busy), 1);
         check({tag, "/done"}, 32'(done), 32'(cyc == done_at));
         check({tag, "/sat_done"}, 32'(done_s), 32'(cyc == done_at));
         if (k == 0) begin
            check({tag, "/clr_err"}, 32'(err_count), 0);
            check({tag, "/clr_sum"}, 32'(hd_sum), 0);
            check({tag, "/clr_fv"}, 32'(first_viol_valid), 0);
         end
         if (cyc == done_at) begin
            check_results(tag);
            fin = 1;
            in_valid = 1'b0;
         end else begin
            case (mode)
               0: v = 1'b1;
               1: v = (k % 2 == 0);
               default: v = 1'($urandom_range(0, 1));
            endcase
            v = v && (se_q.size() > 0);
            in_valid = v;
            in_exact = v ? se_q[0] : WIDTH'($urandom);
            in_approx = v ? sa_q[0] : WIDTH'($urandom);
            if (v && exp_rdy) begin
               exp_q.push_back(HW'($countones(se_q[0] ^ sa_q[0])));
               void'(se_q.pop_front());
               void'(sa_q.pop_front());
               acc++;
               if (acc == n) done_at = cyc + 3;
            end
         end
      end
      if (!fin) check({tag, "/timeout"}, 0, 1);
      @(negedge clk);
      start = 1'b0;
      check({tag, "/post_busy"}, 32'(busy), 0);
      check({tag, "/post_done"}, 32'(done), 0);
      check({tag, "/post_ready"}, 32'(in_ready), 0);
      check_results({tag, "/hold"});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/in_ready"}, 32'(in_ready), 0);
      check({tag, "/busy"}, 32'(busy), 0);
      check({tag, "/done"}, 32'(done), 0);
      check({tag, "/err_count"}, 32'(err_count), 0);
      check({tag, "/hd_sum"}, 32'(hd_sum), 0);
      check({tag, "/hd_max"}, 32'(hd_max), 0);
      check({tag, "/fv_valid"}, 32'(first_viol_valid), 0);
      check({tag, "/fv_idx"}, 32'(first_viol_idx), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_samples = '0;
      in_valid = 1'b0;
      in_exact = '0;
      in_approx = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed: HD 0, 1, 8
      se_q.delete(); sa_q.delete();
      push_pair(9'h000, 9'h000);
      push_pair(9'h1FF, 9'h1FE);
      push_pair(9'h0F0, 9'h00F);
      run("basic3", 3, 0, 1'b0);

      // Empty run
      se_q.delete(); sa_q.delete();
      run("n0", 0, 0, 1'b0);

      // Toggling valid with a fifth sample offered, then the same four gap-free
      se_q.delete(); sa_q.delete();
      push_pair(9'h003, 9'h000);
      push_pair(9'h1FF, 9'h1FF);
      push_pair(9'h0AA, 9'h055);
      push_pair(9'h100, 9'h000);
      push_pair(9'h1FF, 9'h000);
      run("toggle4", 4, 1, 1'b0);
      se_q.delete(); sa_q.delete();
      push_pair(9'h003, 9'h000);
      push_pair(9'h1FF, 9'h1FF);
      push_pair(9'h0AA, 9'h055);
      push_pair(9'h100, 9'h000);
      run("gapfree4", 4, 0, 1'b0);

      // Saturation of the 4-bit sum
      se_q.delete(); sa_q.delete();
      for (int i = 0; i < 3; i++) push_pair(9'h000, 9'h1FF);
      run("sat3", 3, 0, 1'b0);

      // Asynchronous reset mid-run after two of five samples
      se_q.delete(); sa_q.delete();
      @(negedge clk);
      start = 1'b1;
      num_samples = CNT_W'(5);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_exact = 9'h007;
      in_approx = 9'h000;
      @(negedge clk);
      in_exact = 9'h00F;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort/pre_err", 32'(err_count), 1);
      #2 rst = 1'b1;
      #1 check_all_zero("abort_async");
      repeat (3) begin
         @(negedge clk);
         check("abort/in_rst_done", 32'(done), 0);
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("abort/no_done", 32'(done), 0);
         check("abort/idle", 32'(busy), 0);
      end

      se_q.delete(); sa_q.delete();
      push_pair(9'h003, 9'h000);
      run("after_abort", 1, 0, 1'b0);

      // Starts during RUN and DONE are ignored
      se_q.delete(); sa_q.delete();
      push_random(6);
      run("glitch_start", 6, 0, 1'b1);

      // Randomised runs
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(1, 20);
         se_q.delete(); sa_q.delete();
         push_random(n + $urandom_range(0, 2));
         run("random", n, (r % 3 == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
      end

      // New run after a populated one starts from cleared results
      se_q.delete(); sa_q.delete();
      run("n0_clear", 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
